// File: rtl/ser_tx_framer.sv
// ser_tx_framer: serializes a parallel word into a framed line
// (start bit 0, DATA_W data bits, stop bit 1), each bit held for
// CLKS_PER_BIT clocks, with a shift strobe for a downstream register.
//
// Handshake: a word transfers on a rising edge where in_valid and in_ready
// are both 1. in_ready depends only on state registers, never on in_valid.
// The source keeps in_valid and in_data stable until that edge. An offer
// made while in_ready is 0 is ignored.
module ser_tx_framer #(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   input  logic              msb_first,
   output logic              in_ready,
   output logic              ser_out,
   output logic              shift_en,
   output logic              busy,
   output logic              frame_done,
   output logic [1:0]        dbg_state_o
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BW = $clog2(DATA_W);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_e;

   state_e              state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [BW-1:0]       bit_q, bit_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic                msb_q, msb_d;
   logic                ser_out_q, ser_out_d;
   logic                shift_en_q, shift_en_d;
   logic                busy_q, busy_d;
   logic                frame_done_q, frame_done_d;
   logic                cnt_last;
   logic                accept;
   logic [BW-1:0]       sel;

   assign cnt_last    = (cnt_q == CNT_LAST);
   assign in_ready    = (state_q == IDLE) || ((state_q == STOP) && cnt_last);
   assign accept      = in_valid && in_ready;
   assign ser_out     = ser_out_q;
   assign shift_en    = shift_en_q;
   assign busy        = busy_q;
   assign frame_done  = frame_done_q;
   assign dbg_state_o = state_q;

   // Next-state logic; the line outputs are computed from the next state so
   // they can be registered and still line up with the state they describe.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      bit_d        = bit_q;
      data_d       = data_q;
      msb_d        = msb_q;
      ser_out_d    = 1'b1;
      shift_en_d   = 1'b0;
      busy_d       = 1'b0;
      frame_done_d = 1'b0;
      sel          = '0;

      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = START;
               cnt_d   = '0;
               data_d  = in_data;
               msb_d   = msb_first;
            end
         end
         START: begin
            if (cnt_last) begin
               state_d = DATA;
               cnt_d   = '0;
               bit_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         DATA: begin
            if (cnt_last) begin
               cnt_d = '0;
               if (bit_q == BIT_LAST) begin
                  state_d = STOP;
                  bit_d   = '0;
               end else begin
                  bit_d = bit_q + BW'(1);
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         STOP: begin
            if (cnt_last) begin
               cnt_d = '0;
               if (accept) begin
                  // Back-to-back frame: no idle gap after the stop bit.
                  state_d = START;
                  data_d  = in_data;
                  msb_d   = msb_first;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            bit_d   = '0;
         end
      endcase

      // Period k carries bit k (LSB first) or bit DATA_W-1-k (MSB first).
      sel = msb_d ? (BIT_LAST - bit_d) : bit_d;
      case (state_d)
         START:   ser_out_d = 1'b0;
         DATA:    ser_out_d = data_d[sel];
         default: ser_out_d = 1'b1;
      endcase
      shift_en_d   = (state_d == DATA) && (cnt_d == CNT_LAST);
      frame_done_d = (state_d == STOP) && (cnt_d == CNT_LAST);
      busy_d       = (state_d != IDLE);
   end

   // State, counters, data latch and registered outputs; reset aborts a frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         bit_q        <= '0;
         data_q       <= '0;
         msb_q        <= 1'b0;
         ser_out_q    <= 1'b1;
         shift_en_q   <= 1'b0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         bit_q        <= bit_d;
         data_q       <= data_d;
         msb_q        <= msb_d;
         ser_out_q    <= ser_out_d;
         shift_en_q   <= shift_en_d;
         busy_q       <= busy_d;
         frame_done_q <= frame_done_d;
      end
   end

endmodule

// File: tb/tb_ser_tx_framer.sv
// Bench for ser_tx_framer: unit A uses defaults (8 bits, 4 clocks/bit),
// unit B uses 1 clock/bit. Each unit's outputs are compared every cycle
// with a frame waveform generated from the bit-period arithmetic.
module tb_ser_tx_framer;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic       valid_a, msb_a, ready_a, ser_a, shift_a, busy_a, done_a;
   logic [7:0] data_a;
   logic [1:0] st_a;
   logic       valid_b, msb_b, ready_b, ser_b, shift_b, busy_b, done_b;
   logic [7:0] data_b;
   logic [1:0] st_b;

   ser_tx_framer #(.DATA_W(8), .CLKS_PER_BIT(4)) dut_a (
      .clk(clk), .rst_n(rst_n), .in_valid(valid_a), .in_data(data_a),
      .msb_first(msb_a), .in_ready(ready_a), .ser_out(ser_a),
      .shift_en(shift_a), .busy(busy_a), .frame_done(done_a),
      .dbg_state_o(st_a)
   );

   ser_tx_framer #(.DATA_W(8), .CLKS_PER_BIT(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .in_valid(valid_b), .in_data(data_b),
      .msb_first(msb_b), .in_ready(ready_b), .ser_out(ser_b),
      .shift_en(shift_b), .busy(busy_b), .frame_done(done_b),
      .dbg_state_o(st_b)
   );

   // ---------------- scoreboard ----------------
   // Per-cycle tuple: {ser_out, shift_en, frame_done, busy, in_ready}
   localparam logic [4:0] IDLE_T = 5'b10001;
   logic [4:0] exp_a_q[$];
   logic [4:0] exp_b_q[$];
   logic [4:0] cur_a, cur_b;
   int         n_chk, n_pass, cyc;
   bit         acc_a, acc_b, b_auto;
   logic [7:0] sh_a, sh_b;
   int         pulses_a, pulses_b;

   typedef struct {
      logic [7:0] data;
      logic       msb;
      logic [7:0] exp_word;  // left-shift register contents after 8 pulses
   } vec_t;
   vec_t vecs[8];

   // Expected outputs for cycle i (0-based) of a frame.
   function automatic logic [4:0] frame_tuple(logic [7:0] d, logic msb, int cpb, int i);
      int   p, ph;
      logic s, sh, last;
      p    = i / cpb;
      ph   = i % cpb;
      if (p == 0)      s = 1'b0;
      else if (p <= 8) s = msb ? d[8 - p] : d[p - 1];
      else             s = 1'b1;
      sh   = (p >= 1) && (p <= 8) && (ph == cpb - 1);
      last = (i == 10 * cpb - 1);
      return {s, sh, last, 1'b1, last};
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
   endtask

   // ---------------- driver: one clock cycle ----------------
   task automatic step;
      acc_a = 1'b0;
      acc_b = 1'b0;
      if (rst_n && valid_a && cur_a[0]) begin
         for (int i = 0; i < 40; i++) exp_a_q.push_back(frame_tuple(data_a, msb_a, 4, i));
         acc_a = 1'b1;
      end
      if (rst_n && valid_b && cur_b[0]) begin
         for (int i = 0; i < 10; i++) exp_b_q.push_back(frame_tuple(data_b, msb_b, 1, i));
         acc_b = 1'b1;
      end
      @(posedge clk);
      #1;
      cyc++;
      cur_a = (exp_a_q.size() > 0) ? exp_a_q.pop_front() : IDLE_T;
      cur_b = (exp_b_q.size() > 0) ? exp_b_q.pop_front() : IDLE_T;
      check("wave_a", 32'({ser_a, shift_a, done_a, busy_a, ready_a}), 32'(cur_a));
      check("wave_b", 32'({ser_b, shift_b, done_b, busy_b, ready_b}), 32'(cur_b));
      if (acc_a) begin sh_a = '0; pulses_a = 0; end
      if (acc_b) begin sh_b = '0; pulses_b = 0; end
      if (shift_a) begin sh_a = {sh_a[6:0], ser_a}; pulses_a++; end
      if (shift_b) begin sh_b = {sh_b[6:0], ser_b}; pulses_b++; end
      if (b_auto) begin
         if (acc_b) valid_b = 1'b0;
         if (!valid_b) begin
            data_b = 8'($urandom);
            msb_b  = 1'($urandom);
            if ($urandom_range(0, 2) == 0) valid_b = 1'b1;
         end
      end
   endtask

   task automatic send_a(input logic [7:0] w, input logic m, input bit keep);
      int n = 0;
      valid_a = 1'b1; data_a = w; msb_a = m;
      step;
      while (!acc_a && n < 100) begin step; n++; end
      if (!acc_a) check("accept_a_timeout", 0, 1);
      if (!keep) valid_a = 1'b0;
   endtask

   task automatic send_b(input logic [7:0] w, input logic m);
      int n = 0;
      valid_b = 1'b1; data_b = w; msb_b = m;
      step;
      while (!acc_b && n < 100) begin step; n++; end
      if (!acc_b) check("accept_b_timeout", 0, 1);
      valid_b = 1'b0;
   endtask

   task automatic wait_idle;
      int n = 0;
      while ((exp_a_q.size() > 0 || cur_a != IDLE_T || exp_b_q.size() > 0 || cur_b != IDLE_T)
             && n < 300) begin
         step; n++;
      end
      if (n >= 300) check("idle_timeout", 0, 1);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int c0, p0;
      n_chk = 0; n_pass = 0; cyc = 0; b_auto = 1'b0;
      rst_n = 1'b0;
      valid_a = 1'b0; data_a = '0; msb_a = 1'b0;
      valid_b = 1'b0; data_b = '0; msb_b = 1'b0;
      cur_a = IDLE_T; cur_b = IDLE_T;
      sh_a = '0; sh_b = '0; pulses_a = 0; pulses_b = 0;

      vecs[0] = '{8'hA5, 1'b0, 8'hA5};
      vecs[1] = '{8'hA5, 1'b1, 8'hA5};
      vecs[2] = '{8'h01, 1'b0, 8'h80};
      vecs[3] = '{8'h01, 1'b1, 8'h01};
      vecs[4] = '{8'hF0, 1'b0, 8'h0F};
      vecs[5] = '{8'h12, 1'b0, 8'h48};
      vecs[6] = '{8'h12, 1'b1, 8'h12};
      vecs[7] = '{8'hC3, 1'b1, 8'hC3};

      // Reset values while rst_n is low.
      #12;
      check("reset_a", 32'({ser_a, shift_a, done_a, busy_a}), 32'(4'b1000));
      check("reset_b", 32'({ser_b, shift_b, done_b, busy_b}), 32'(4'b1000));
      check("reset_state_a", 32'(st_a), 0);
      #1 rst_n = 1'b1;
      repeat (2) step;

      // Table-driven single frames on unit A.
      for (int k = 0; k < 8; k++) begin
         send_a(vecs[k].data, vecs[k].msb, 1'b0);
         wait_idle;
         check("word_a", 32'(sh_a), 32'(vecs[k].exp_word));
         check("pulses_a", pulses_a, 8);
      end

      // Back-to-back frames: second accepted on the first frame's last cycle.
      send_a(8'h3C, 1'b0, 1'b1);
      c0 = cyc;
      send_a(8'hC3, 1'b0, 1'b0);
      check("b2b_spacing", cyc - c0, 40);
      wait_idle;
      check("b2b_word", 32'(sh_a), 32'(8'hC3));

      // Offer during DATA is held off until the final STOP cycle.
      send_a(8'h55, 1'b1, 1'b0);
      repeat (10) step;
      c0 = cyc;
      send_a(8'h9E, 1'b0, 1'b0);
      check("late_accept", cyc - c0, 30);
      wait_idle;
      check("late_word", 32'(sh_a), 32'(8'h79));

      // One clock per bit; input changes mid-frame must not matter.
      send_b(8'hFF, 1'b0);
      repeat (3) step;
      data_b = 8'h00; msb_b = 1'b1;
      wait_idle;
      check("cpb1_word", 32'(sh_b), 32'(8'hFF));
      check("cpb1_pulses", pulses_b, 8);

      // Reset at frame cycle 15 aborts immediately.
      send_a(8'hA5, 1'b0, 1'b0);
      repeat (14) step;
      rst_n = 1'b0;
      #1;
      check("abort_out", 32'({ser_a, shift_a, done_a, busy_a}), 32'(4'b1000));
      exp_a_q.delete(); exp_b_q.delete();
      cur_a = IDLE_T; cur_b = IDLE_T;
      p0 = pulses_a;
      #2 rst_n = 1'b1;
      repeat (45) step;
      check("abort_no_pulses", pulses_a, p0);

      // Random traffic on both units.
      b_auto = 1'b1;
      for (int it = 0; it < 25; it++) begin
         send_a(8'($urandom), 1'($urandom), 1'b0);
         repeat ($urandom_range(0, 45)) begin
            data_a = 8'($urandom); msb_a = 1'($urandom);
            step;
         end
      end
      b_auto = 1'b0;
      valid_b = 1'b0;
      wait_idle;
      repeat (3) step;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/ser_tx_framer.md
SER_TX_FRAMER -- requirements
Module: ser_tx_framer

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the parallel word width (legal range >= 2).
REQ-002 Parameter CLKS_PER_BIT, default 4, SHALL set clock cycles per serial bit period (legal range >= 1).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 in_valid  input  1  SHALL flag that in_data holds a word to send.
REQ-006 in_data  input  DATA_W  SHALL be the parallel word to serialize.
REQ-007 msb_first  input  1  SHALL select bit order: 1 sends MSB first, 0 sends LSB first.
REQ-008 in_ready  output  1  SHALL flag that a word offered this cycle will be accepted.
REQ-009 ser_out  output  1  SHALL be the framed serial line, idle high; it feeds the right_in/left_in input of the downstream shift register.
REQ-010 shift_en  output  1  SHALL be a one-cycle strobe marking the cycle in which the downstream register samples the current data bit.
REQ-011 busy  output  1  SHALL be high whenever a frame is in progress (state is not IDLE).
REQ-012 frame_done  output  1  SHALL be a one-cycle pulse on the last cycle of the stop bit.

Function
REQ-013 The block SHALL use the states IDLE, START, DATA and STOP.
REQ-014 A transfer SHALL occur on a rising edge where in_valid and in_ready are both 1; in_data and msb_first are latched on that edge.
REQ-015 in_ready SHALL be 1 in IDLE and on the final cycle of STOP, and 0 otherwise.
REQ-016 After a transfer, the state SHALL move to START on the next cycle; ser_out = 0 for exactly CLKS_PER_BIT cycles.
REQ-017 DATA SHALL last DATA_W bit periods of CLKS_PER_BIT cycles each.
REQ-018 In DATA, ser_out SHALL carry latched bit k in period k: bit k for msb_first=0, bit DATA_W-1-k for msb_first=1.
REQ-019 shift_en SHALL be 1 on the last cycle of each DATA bit period, giving exactly DATA_W pulses per frame; it is 0 in all other states.
REQ-020 STOP SHALL drive ser_out = 1 for CLKS_PER_BIT cycles; frame_done is 1 on its last cycle.
REQ-021 At the end of STOP, the state SHALL go to START if a transfer occurs on that edge (back-to-back, no idle gap), else to IDLE.
REQ-022 Frame length SHALL be (DATA_W+2)*CLKS_PER_BIT cycles; the default is 40 cycles.
REQ-023 The cycle counter SHALL be ceil(log2(CLKS_PER_BIT)) bits (minimum 1) and wrap to 0 at CLKS_PER_BIT-1.
REQ-024 The bit index SHALL be ceil(log2(DATA_W)) bits and SHALL NOT exceed DATA_W-1.
REQ-025 With CLKS_PER_BIT = 1, shift_en SHALL be high on every DATA cycle.
REQ-026 in_data and msb_first changes during a frame SHALL NOT affect the frame in flight.
REQ-027 in_valid while in_ready = 0 SHALL be ignored, not queued; the source holds in_valid until a transfer.
REQ-028 ser_out, shift_en, busy and frame_done SHALL be registered outputs (no combinational path from inputs); in_ready is a decode of state registers only.

Reset
REQ-029 While rst_n = 0: state = IDLE, ser_out = 1, shift_en = 0, busy = 0, frame_done = 0, counters = 0, data latch = 0.
REQ-030 rst_n assertion mid-frame SHALL abort the frame immediately (asynchronously); no shift_en or frame_done pulse follows.
REQ-031 in_ready SHALL be 1 on the first cycle after rst_n deassertion.

Verification
REQ-032 Single LSB-first frame, defaults, in_data = 8'hA5, msb_first = 0 -> ser_out: 4 cycles 0, then bits 1,0,1,0,0,1,0,1 for 4 cycles each, then 4 cycles 1; 8 shift_en pulses; frame_done at cycle 40.
REQ-033 Same word with msb_first = 1 -> data bits 1,0,1,0,0,1,0,1; a downstream left-shift register sampling on shift_en holds 8'hA5 after the 8th pulse.
REQ-034 Back-to-back: in_valid held high with 8'h3C then 8'hC3 -> second START begins the cycle after the first frame_done; 80 cycles total; ser_out never idles high between frames beyond the stop bit.
REQ-035 rst_n pulsed low at cycle 15 of a frame -> ser_out = 1 and busy = 0 immediately; in_ready = 1 next cycle; no further shift_en pulses.
REQ-036 CLKS_PER_BIT = 1, DATA_W = 8, in_data = 8'hFF -> 10-cycle frame; shift_en high on cycles 2-9; in_data changed to 8'h00 mid-frame -> output unchanged.
REQ-037 in_valid asserted during DATA with in_ready = 0 -> no transfer until the final STOP cycle; the word is accepted there.
